// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Exports address/data widths, reset PC and the queue entry structs.
package fetch_pkg;

  localparam int unsigned FETCH_AW = 32;
  localparam int unsigned FETCH_DW = 32;
  localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  // live sits in bit 0 so the FIFO can clear it without knowing the layout
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic                live;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush/count and a kill that clears bit 0.
// Ports: clk, rst, push, pop, flush, kill, din -> dout (head), count.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   kill,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && (count != '0);
  // a full queue still takes a push when the head leaves this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop)  rd <= nxt(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill) mem[i][0] <= 1'b0;
    end
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem requests,
// queues responses for decode; redirect squashes in-flight work.
// Ports: clk, rst, imem_req_*, imem_resp_*, redirect_*, dec_*.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = FETCH_AW,
  parameter int DATA_WIDTH      = FETCH_DW,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] dec_pc_plus4,
  output logic [24:0]           dec_instr_imm
);

  localparam int TW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = ((TW > QW) ? TW : QW) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  fetch_tag_t            tag_in;
  fetch_tag_t            tag_out;
  fetch_entry_t          ent_in;
  fetch_entry_t          ent_out;
  logic [TW-1:0]         outstanding;
  logic [QW-1:0]         qcount;
  logic [UW-1:0]         used;
  logic                  req_fire;
  logic                  q_push;
  logic                  q_empty;
  logic                  dec_fire;
  logic                  unused_low;

  // buffered plus in-flight never exceeds the queue depth
  assign used = UW'(outstanding) + UW'(qcount);

  assign imem_req_valid = !rst && !redirect_valid
                       && (outstanding < TW'(MAX_OUTSTANDING))
                       && (used < UW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign tag_in = '{pc: fetch_pc, live: 1'b1};
  assign ent_in = '{pc: tag_out.pc, instr: imem_resp_data};
  assign q_push = imem_resp_valid && tag_out.live && !redirect_valid;

  assign q_empty   = qcount == '0;
  assign dec_valid = !q_empty && !redirect_valid && !rst;
  assign dec_fire  = dec_valid && dec_ready;

  assign dec_instr     = q_empty ? '0 : ent_out.instr;
  assign dec_pc        = q_empty ? '0 : ent_out.pc;
  assign dec_pc_plus4  = q_empty ? '0 : ent_out.pc + ADDR_WIDTH'(4);
  assign dec_instr_imm = dec_instr[31:7];

  assign unused_low = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
    end
  end

  // stale tags keep draining after a redirect; only their live bit drops
  fetch_fifo #(
    .W     ($bits(fetch_tag_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .kill  (redirect_valid),
    .din   (tag_in),
    .dout  (tag_out),
    .count (outstanding)
  );

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (dec_fire),
    .flush (redirect_valid),
    .kill  (1'b0),
    .din   (ent_in),
    .dout  (ent_out),
    .count (qcount)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences,
// a redirect vector table and a randomized run against a stream model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [24:0] dec_instr_imm;

  int n_cmp = 0;
  int n_fail = 0;

  // 0: always ready, 1: random, 2: held low
  int ready_mode = 0;
  // 0: answer asap, 1: random, 2: hold, 3: answer once then hold
  int resp_mode = 0;
  logic rnd_ready = 1'b0;

  logic [31:0] pending [$];
  logic [31:0] got_pcs [$];
  logic [31:0] got_reqs [$];
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;

  always #5 clk = ~clk;

  assign imem_req_ready = (ready_mode == 0) || (ready_mode == 1 && rnd_ready);

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pc_plus4    (dec_pc_plus4),
    .dec_instr_imm   (dec_instr_imm)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'hFFF0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // in-order memory: one response per accepted request, reset with the DUT
  logic        s_rst, s_req, s_resp;
  logic [31:0] s_addr;
  always begin
    logic go;
    @(negedge clk);
    s_rst  = rst;
    s_req  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_resp = imem_resp_valid;
    @(posedge clk);
    #1;
    if (s_rst) begin
      pending.delete();
    end else begin
      if (s_resp) void'(pending.pop_front());
      if (s_req) pending.push_back(s_addr);
    end
    rnd_ready = 1'($urandom % 2);
    go = 1'b0;
    if (pending.size() != 0) begin
      case (resp_mode)
        0: go = 1'b1;
        1: go = 1'($urandom % 2);
        3: begin go = 1'b1; resp_mode = 2; end
        default: go = 1'b0;
      endcase
    end
    imem_resp_valid = go;
    imem_resp_data  = go ? memf(pending[0]) : 32'h0;
  end

  // reference: both streams run sequentially from the latest restart point
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      exp_pc  = 32'h0;
      exp_req = 32'h0;
    end else if (redirect_valid) begin
      chk("redir_req_valid", imem_req_valid, 0);
      exp_pc  = redirect_pc & ~32'h3;
      exp_req = redirect_pc & ~32'h3;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req);
        got_reqs.push_back(imem_req_addr);
        exp_req = exp_req + 32'h4;
      end
      if (dec_valid && dec_ready) begin
        chk("dec_pc", dec_pc, exp_pc);
        chk("dec_instr", dec_instr, memf(exp_pc));
        chk("dec_pc_plus4", dec_pc_plus4, exp_pc + 32'h4);
        chk("dec_imm", {7'h0, dec_instr_imm}, memf(exp_pc) >> 7);
        got_pcs.push_back(dec_pc);
        exp_pc = exp_pc + 32'h4;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    drv();
    drv();
    rst = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc = p;
    smp();
    chk("redir_dec_valid", dec_valid, 0);
    drv();
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs [5];

  initial begin
    int k;
    vecs[0] = '{32'h0000_0103, 32'h0000_0100};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0002, 32'h0000_0000};
    vecs[4] = '{32'h1234_567A, 32'h1234_5678};

    drv();

    // 1: latency, address sequence, immediate slice
    ready_mode = 0; resp_mode = 0; dec_ready = 1'b1;
    do_reset();
    smp();
    chk("t1_dv_c1", dec_valid, 0);
    chk("t1_addr0", imem_req_addr, 32'h0);
    drv(); smp();
    chk("t1_dv_c2", dec_valid, 0);
    chk("t1_addr1", imem_req_addr, 32'h4);
    drv(); smp();
    chk("t1_dv_c3", dec_valid, 1);
    chk("t1_addr2", imem_req_addr, 32'h8);
    chk("t1_pc", dec_pc, 32'h0);
    chk("t1_pc4", dec_pc_plus4, 32'h4);
    chk("t1_imm", {7'h0, dec_instr_imm}, 32'h01FF_E001);
    drv();

    // 2: decode backpressure fills the credit, then drains in order
    dec_ready = 1'b0;
    got_pcs.delete();
    do_reset();
    repeat (10) begin smp(); drv(); end
    smp();
    chk("t2_req_stall", imem_req_valid, 0);
    chk("t2_dv", dec_valid, 1);
    chk("t2_head", dec_pc, 32'h0);
    drv();
    dec_ready = 1'b1;
    k = 0;
    while (got_pcs.size() < 3 && k < 20) begin smp(); drv(); k++; end
    chk("t2_drained", 32'(got_pcs.size() >= 3), 1);
    for (int i = 0; i < 3; i++)
      chk("t2_order", (got_pcs.size() > i) ? got_pcs[i] : 32'hDEAD_BEEF,
          32'(i * 4));

    // 3: redirect with two requests in flight
    resp_mode = 2;
    do_reset();
    redirect_pulse(32'h8);
    k = 0;
    smp();
    while (pending.size() != 2 && k < 20) begin drv(); smp(); k++; end
    chk("t3_two_out", pending.size(), 2);
    chk("t3_out0", (pending.size() > 0) ? pending[0] : 32'hDEAD_BEEF, 32'h8);
    chk("t3_out1", (pending.size() > 1) ? pending[1] : 32'hDEAD_BEEF, 32'hC);
    drv();
    resp_mode = 0;
    redirect_pulse(32'h100);
    k = 0;
    smp();
    while (!dec_valid && k < 30) begin drv(); smp(); k++; end
    chk("t3_dv", dec_valid, 1);
    chk("t3_pc", dec_pc, 32'h100);
    drv();

    // 4: redirect alignment table and PC wrap
    foreach (vecs[i]) begin
      redirect_pulse(vecs[i].rpc);
      smp();
      chk("t4_addr", imem_req_addr, vecs[i].exp_addr);
      drv();
    end
    got_reqs.delete();
    redirect_pulse(32'hFFFF_FFFC);
    repeat (12) begin smp(); drv(); end
    chk("t4_wrap_a", (got_reqs.size() > 0) ? got_reqs[0] : 32'hDEAD_BEEF,
        32'hFFFF_FFFC);
    chk("t4_wrap_b", (got_reqs.size() > 1) ? got_reqs[1] : 32'hDEAD_BEEF,
        32'h0);

    // 5: request held while memory is not ready
    ready_mode = 2;
    redirect_pulse(32'h10);
    k = 0;
    smp();
    while (!(imem_req_valid && pending.size() == 0) && k < 30) begin
      drv(); smp(); k++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("t5_valid", imem_req_valid, 1);
      chk("t5_addr", imem_req_addr, 32'h10);
      drv();
      if (i < 2) smp();
    end
    ready_mode = 0;
    smp();
    drv();
    smp();
    chk("t5_one_tag", pending.size(), 1);
    chk("t5_tag", (pending.size() > 0) ? pending[0] : 32'hDEAD_BEEF, 32'h10);
    drv();

    // 6: reset pulse with full credit (one buffered, one in flight)
    resp_mode = 2;
    dec_ready = 1'b0;
    do_reset();
    k = 0;
    smp();
    while (pending.size() != 2 && k < 20) begin drv(); smp(); k++; end
    chk("t6_two_out", pending.size(), 2);
    drv();
    resp_mode = 3;
    k = 0;
    smp();
    while (!(dec_valid && pending.size() == 1) && k < 20) begin
      drv(); smp(); k++;
    end
    chk("t6_buffered", dec_valid, 1);
    drv();
    rst = 1'b1;
    smp();
    chk("t6_rst_dv", dec_valid, 0);
    chk("t6_rst_rv", imem_req_valid, 0);
    drv();
    rst = 1'b0;
    smp();
    chk("t6_post_rv", imem_req_valid, 1);
    chk("t6_post_addr", imem_req_addr, 32'h0);
    chk("t6_post_dv", dec_valid, 0);
    drv();
    resp_mode = 0;
    dec_ready = 1'b1;
    got_pcs.delete();
    repeat (15) begin smp(); drv(); end
    chk("t6_first", (got_pcs.size() > 0) ? got_pcs[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t6_second", (got_pcs.size() > 1) ? got_pcs[1] : 32'hDEAD_BEEF, 32'h4);

    // randomized traffic against the stream model
    ready_mode = 1;
    resp_mode = 1;
    got_pcs.delete();
    for (int c = 0; c < 3000; c++) begin
      dec_ready = ($urandom % 4) != 0;
      rst = ($urandom % 300) == 0;
      redirect_valid = ($urandom % 24) == 0;
      redirect_pc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                          : $urandom;
      drv();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    smp();
    chk("rand_progress", 32'(got_pcs.size() > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
